// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants for the RV32M multi-cycle unit:
// ALU_OP encodings, FSM states, default width.
package muldiv_sequencer_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [4:0] OP_MUL    = 5'b11000;
  localparam logic [4:0] OP_MULH   = 5'b11001;
  localparam logic [4:0] OP_MULHSU = 5'b11010;
  localparam logic [4:0] OP_MULHU  = 5'b11011;
  localparam logic [4:0] OP_DIV    = 5'b11100;
  localparam logic [4:0] OP_REM    = 5'b11101;
  localparam logic [4:0] OP_FWD    = 5'b11110;
  localparam logic [4:0] OP_REMU   = 5'b11111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_e;

  // 11110 shares the M prefix but is the
  // forward op, so it is not ours.
  function automatic logic is_muldiv(
    input logic [4:0] op
  );
    return (op[4:3] == 2'b11) && (op != OP_FWD);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage request/response bundle for the mul/div unit.
// master: pipeline (START/FLUSH/ALU_OP/DATA*), slave: unit.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            START;
  logic            FLUSH;
  logic [4:0]      ALU_OP;
  logic [XLEN-1:0] DATA1;
  logic [XLEN-1:0] DATA2;
  logic            BUSY;
  logic            STALL;
  logic            DONE;
  logic [XLEN-1:0] RESULT;

  modport master (
    output START, FLUSH, ALU_OP, DATA1, DATA2,
    input  BUSY, STALL, DONE, RESULT
  );

  modport slave (
    input  START, FLUSH, ALU_OP, DATA1, DATA2,
    output BUSY, STALL, DONE, RESULT
  );
endinterface

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring
// divide on a 2*XLEN accumulator. Ports: load/step/mode_div, opnd, init_lo, acc.
module muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              mode_div,
  input  logic [XLEN-1:0]   opnd,
  input  logic [XLEN-1:0]   init_lo,
  output logic [2*XLEN-1:0] acc
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     shl_hi;
  logic [XLEN:0]     diff;

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    // multiply: add multiplicand into hi when lsb set
    sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
        + {1'b0, (acc_q[0] ? opnd_q : '0)};
    // divide: partial remainder after left shift
    shl_hi = acc_q[2*XLEN-1:XLEN-1];
    diff   = shl_hi - {1'b0, opnd_q};
    if (load) begin
      acc_d  = {{XLEN{1'b0}}, init_lo};
      opnd_d = opnd;
    end else if (step) begin
      if (!mode_div) begin
        acc_d = {sum, acc_q[XLEN-1:1]};
      end else if (shl_hi >= {1'b0, opnd_q}) begin
        acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {shl_hi[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle controller: FSM, counter, sign and special cases.
// Ports: CLK, RESET, bus (slave: START/FLUSH/ALU_OP/DATA1/DATA2 -> BUSY/STALL/DONE/RESULT).
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            neg_q, neg_d, rneg_q, rneg_d;
  logic            div0_q, div0_d, ovf_q, ovf_d;
  logic            busy_q, busy_d, done_q, done_d;

  logic            is_div, sgn_a, sgn_b, accept;
  logic [XLEN-1:0] mag_a, mag_b, core_opnd, core_lo;
  logic [XLEN-1:0] quo, rem, fix_val;
  logic [2*XLEN-1:0] acc, prod;

  always_comb begin
    is_div = op_q[2];
    sgn_a  = a_q[XLEN-1] & (op_q == OP_MULH || op_q == OP_MULHSU
                         || op_q == OP_DIV  || op_q == OP_REM);
    sgn_b  = b_q[XLEN-1] & (op_q == OP_MULH || op_q == OP_DIV
                         || op_q == OP_REM);
    mag_a  = sgn_a ? -a_q : a_q;
    mag_b  = sgn_b ? -b_q : b_q;
    core_opnd = is_div ? mag_b : mag_a;
    core_lo   = is_div ? mag_a : mag_b;
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk      (CLK),
    .rst      (RESET),
    .load     (state_q == ST_PREP),
    .step     (state_q == ST_CALC),
    .mode_div (is_div),
    .opnd     (core_opnd),
    .init_lo  (core_lo),
    .acc      (acc)
  );

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = rneg_q ? -acc[2*XLEN-1:XLEN]
                  : acc[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:    fix_val = prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  fix_val = prod[2*XLEN-1:XLEN];
      OP_DIV:    fix_val = div0_q ? '1 : (ovf_q ? SMIN : quo);
      default:   fix_val = div0_q ? a_q : (ovf_q ? '0 : rem);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    accept  = bus.START & ~bus.FLUSH & is_muldiv(bus.ALU_OP);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_PREP;
          op_d    = bus.ALU_OP;
          a_d     = bus.DATA1;
          b_d     = bus.DATA2;
        end
      end
      ST_PREP: begin
        neg_d   = sgn_a ^ sgn_b;
        rneg_d  = sgn_a;
        div0_d  = (b_q == '0);
        ovf_d   = (op_q == OP_DIV || op_q == OP_REM)
                && a_q == SMIN && b_q == '1;
        cnt_d   = '0;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        res_d   = fix_val;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.FLUSH && state_q inside {ST_PREP, ST_CALC, ST_FIX}) begin
      state_d = ST_IDLE;
      res_d   = res_q;
    end
    busy_d = state_d inside {ST_PREP, ST_CALC, ST_FIX};
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.BUSY   = busy_q;
  assign bus.STALL  = busy_q;
  assign bus.DONE   = done_q;
  assign bus.RESULT = res_q;

endmodule
